// File: rtl/bit_stream_serializer_pkg.sv
// Shared definitions for the bit stream serializer: FSM encoding and default sizes.
package bit_stream_serializer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_CNT_W = 16;

endpackage

// File: rtl/bit_stream_serializer_if.sv
// Parallel word input and serial bit output bundle of the serializer.
interface bit_stream_serializer_if
  import bit_stream_serializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) ();

  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             data_ready;
  logic             serial_bit;
  logic             bit_valid;
  logic             word_done;
  logic             busy;
  logic [CNT_W-1:0] words_sent;

  modport master (
    output data_in, data_valid,
    input  data_ready, serial_bit, bit_valid, word_done, busy, words_sent
  );

  modport slave (
    input  data_in, data_valid,
    output data_ready, serial_bit, bit_valid, word_done, busy, words_sent
  );

endinterface

// File: rtl/bit_stream_serializer.sv
// Purpose: parallel-to-serial front end, one bit per clock, words back-to-back.
// Latency: first bit on serial_bit the cycle after the accept edge.
// Backpressure: data_ready only when idle or on the last bit of the current word.
module bit_stream_serializer
  import bit_stream_serializer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0,
  parameter int CNT_W     = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  bit_stream_serializer_if.slave bus
);

  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST_IDX = BW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [BW-1:0]    bit_cnt, bit_cnt_nxt;
  logic             serial_bit_q, bit_valid_q, word_done_q;
  logic             serial_bit_nxt, bit_valid_nxt, word_done_nxt;
  logic [CNT_W-1:0] words_sent_q;
  logic             last_bit;
  logic             accept;

  function automatic logic head_of(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_of(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
  endfunction

  assign last_bit       = (state == ST_SHIFT) && (bit_cnt == LAST_IDX);
  assign bus.data_ready = !reset && ((state == ST_IDLE) || last_bit);
  assign accept         = bus.data_valid && bus.data_ready;

  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          shreg_nxt   = bus.data_in;
          bit_cnt_nxt = '0;
          state_nxt   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (last_bit) begin
          bit_cnt_nxt = '0;
          if (accept) shreg_nxt = bus.data_in;
          else        state_nxt = ST_IDLE;
        end else begin
          shreg_nxt   = shift_of(shreg);
          bit_cnt_nxt = bit_cnt + BW'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Outputs are registered, so they are derived from the next-cycle state.
    serial_bit_nxt = IDLE_BIT;
    bit_valid_nxt  = 1'b0;
    word_done_nxt  = 1'b0;
    if (state_nxt == ST_SHIFT) begin
      serial_bit_nxt = head_of(shreg_nxt);
      bit_valid_nxt  = 1'b1;
      word_done_nxt  = (bit_cnt_nxt == LAST_IDX);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      shreg        <= '0;
      bit_cnt      <= '0;
      serial_bit_q <= IDLE_BIT;
      bit_valid_q  <= 1'b0;
      word_done_q  <= 1'b0;
      words_sent_q <= '0;
    end else begin
      state        <= state_nxt;
      shreg        <= shreg_nxt;
      bit_cnt      <= bit_cnt_nxt;
      serial_bit_q <= serial_bit_nxt;
      bit_valid_q  <= bit_valid_nxt;
      word_done_q  <= word_done_nxt;
      if (last_bit && !(&words_sent_q))
        words_sent_q <= words_sent_q + CNT_W'(1);
    end
  end

  assign bus.serial_bit = serial_bit_q;
  assign bus.bit_valid  = bit_valid_q;
  assign bus.word_done  = word_done_q;
  assign bus.busy       = (state == ST_SHIFT);
  assign bus.words_sent = words_sent_q;

endmodule

// File: tb/tb_bit_stream_serializer.sv
// Directed bench: MSB-first instance with a 0101 detector model, LSB-first instance with a 2-bit counter.
module tb_bit_stream_serializer;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  always #5 clk = ~clk;

  bit_stream_serializer_if #(.WIDTH(W), .CNT_W(16)) ia ();
  bit_stream_serializer_if #(.WIDTH(W), .CNT_W(2))  ib ();

  bit_stream_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0), .CNT_W(16)) dut_a (
    .clk   (clk),
    .reset (rst_a),
    .bus   (ia.slave)
  );

  bit_stream_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0), .CNT_W(2)) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .bus   (ib.slave)
  );

  // Overlapping Mealy 0101 detector fed by serial_bit of the MSB-first instance.
  logic [3:0] hist_a;
  logic       det_a;
  always @(posedge clk) begin
    if (rst_a)             hist_a <= 4'b1111;
    else if (ia.bit_valid) hist_a <= {hist_a[2:0], ia.serial_bit};
  end
  assign det_a = ia.bit_valid && ({hist_a[2:0], ia.serial_bit} == 4'b0101);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] p;
    logic [7:0] seq;
    logic [7:0] det_exp;

    ia.data_in = '0; ia.data_valid = 1'b0;
    ib.data_in = '0; ib.data_valid = 1'b0;
    rst_a = 1'b1; rst_b = 1'b1;

    // 1: reset held three cycles, then released
    repeat (3) tick();
    chk("rst_ready_a", 32'(ia.data_ready), 32'd0);
    chk("rst_ready_b", 32'(ib.data_ready), 32'd0);
    rst_a = 1'b0;
    #1;
    chk("rst_serial", 32'(ia.serial_bit), 32'd0);
    chk("rst_bvalid", 32'(ia.bit_valid), 32'd0);
    chk("rst_ready", 32'(ia.data_ready), 32'd1);
    chk("rst_words", 32'(ia.words_sent), 32'd0);
    chk("rst_busy", 32'(ia.busy), 32'd0);

    // 2: single word 0101, MSB first
    p = 4'b0101;
    ia.data_in = p; ia.data_valid = 1'b1;
    tick();
    ia.data_valid = 1'b0;
    for (int i = 0; i < W; i++) begin
      chk($sformatf("w1_bit%0d", i), 32'(ia.serial_bit), 32'(p[3-i]));
      chk($sformatf("w1_bv%0d", i), 32'(ia.bit_valid), 32'd1);
      chk($sformatf("w1_done%0d", i), 32'(ia.word_done), 32'(i == 3));
      chk($sformatf("w1_det%0d", i), 32'(det_a), 32'(i == 3));
      tick();
    end
    chk("w1_idle_bv", 32'(ia.bit_valid), 32'd0);
    chk("w1_idle_bit", 32'(ia.serial_bit), 32'd0);
    chk("w1_words", 32'(ia.words_sent), 32'd1);
    chk("w1_busy", 32'(ia.busy), 32'd0);

    // 3: back-to-back 0010, 1011 with data_valid held high
    seq = 8'b0010_1011;
    det_exp = 8'b0000_1010;
    ia.data_in = 4'b0010; ia.data_valid = 1'b1;
    tick();
    ia.data_in = 4'b1011;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("b2b_bit%0d", i), 32'(ia.serial_bit), 32'(seq[7-i]));
      chk($sformatf("b2b_bv%0d", i), 32'(ia.bit_valid), 32'd1);
      chk($sformatf("b2b_done%0d", i), 32'(ia.word_done), 32'(i == 3 || i == 7));
      chk($sformatf("b2b_det%0d", i), 32'(det_a), 32'(det_exp[7-i]));
      chk($sformatf("b2b_rdy%0d", i), 32'(ia.data_ready), 32'(i == 3 || i == 7));
      if (i == 4) ia.data_valid = 1'b0;
      tick();
    end
    chk("b2b_idle_bv", 32'(ia.bit_valid), 32'd0);
    chk("b2b_words", 32'(ia.words_sent), 32'd3);

    // 5: reset after the second bit of 1111 on the LSB-first instance
    rst_b = 1'b0;
    ib.data_in = 4'b1111; ib.data_valid = 1'b1;
    #1;
    chk("mid_ready0", 32'(ib.data_ready), 32'd1);
    tick();
    ib.data_valid = 1'b0;
    chk("mid_bit0", 32'(ib.serial_bit), 32'd1);
    tick();
    chk("mid_bit1", 32'(ib.serial_bit), 32'd1);
    chk("mid_bv1", 32'(ib.bit_valid), 32'd1);
    rst_b = 1'b1;
    tick();
    chk("mid_rst_bit", 32'(ib.serial_bit), 32'd0);
    chk("mid_rst_bv", 32'(ib.bit_valid), 32'd0);
    chk("mid_rst_done", 32'(ib.word_done), 32'd0);
    chk("mid_rst_words", 32'(ib.words_sent), 32'd0);
    chk("mid_rst_ready", 32'(ib.data_ready), 32'd0);
    rst_b = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("mid_nodone%0d", i), 32'(ib.word_done), 32'd0);
    end
    chk("mid_words", 32'(ib.words_sent), 32'd0);
    chk("mid_busy", 32'(ib.busy), 32'd0);

    // 4: LSB first, word 1100
    p = 4'b1100;
    ib.data_in = p; ib.data_valid = 1'b1;
    tick();
    ib.data_valid = 1'b0;
    ib.data_in = 4'b0011;
    for (int i = 0; i < W; i++) begin
      chk($sformatf("lsb_bit%0d", i), 32'(ib.serial_bit), 32'(p[i]));
      chk($sformatf("lsb_done%0d", i), 32'(ib.word_done), 32'(i == 3));
      tick();
    end
    chk("sat_words1", 32'(ib.words_sent), 32'd1);

    // 6: 2-bit counter saturates at 3 over four more words
    for (int k = 0; k < 4; k++) begin
      ib.data_in = 4'(k + 5); ib.data_valid = 1'b1;
      tick();
      ib.data_valid = 1'b0;
      repeat (W) tick();
      chk($sformatf("sat_words%0d", k + 2), 32'(ib.words_sent), 32'((k + 2 > 3) ? 3 : k + 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
